// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared types, constants and width helpers for the hex display scanner
package hex_disp_pkg;

    typedef logic [6:0] seg_t;

    // All segments off (active-low pins)
    localparam seg_t SEG_BLANK = 7'h7F;

    // Bits needed to index NDIG digits; never narrower than one bit
    function automatic int DIG_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed for a 0..DIV-1 slot counter; never narrower than one bit
    function automatic int CNT_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_scan_ctrl_hex.sv
// rtl/hex_scan_ctrl_hex.sv - 4-bit to active-low 7-segment decoder, bit 6 = a .. bit 0 = g
module hex
    import hex_disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output seg_t       o_seg
);

    // Pure lookup; a lit segment drives its pin low
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'h0: o_seg = 7'b0000001;
            4'h1: o_seg = 7'b1001111;
            4'h2: o_seg = 7'b0010010;
            4'h3: o_seg = 7'b0000110;
            4'h4: o_seg = 7'b1001100;
            4'h5: o_seg = 7'b0100100;
            4'h6: o_seg = 7'b0100000;
            4'h7: o_seg = 7'b0001111;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0000100;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b1100000;
            4'hC: o_seg = 7'b0110001;
            4'hD: o_seg = 7'b1000010;
            4'hE: o_seg = 7'b0110000;
            4'hF: o_seg = 7'b0111000;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-synchronous double buffer
module hex_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              lz_en,
    output logic              pending,
    output logic              frame_tick,
    output seg_t              seg,
    output logic              dp,
    output logic [NDIG-1:0]   an
);

    localparam int CW = CNT_W(DIV);
    localparam int DW = DIG_W(NDIG);

    logic [CW-1:0]     r_div_cnt;
    logic [DW-1:0]     r_dig_idx;
    logic [4*NDIG-1:0] r_sh_data;
    logic [NDIG-1:0]   r_sh_dp;
    logic [4*NDIG-1:0] r_disp_data;
    logic [NDIG-1:0]   r_disp_dp;
    logic              r_pending;
    logic              r_frame_tick;
    seg_t              r_seg;
    logic              r_dp;
    logic [NDIG-1:0]   r_an;

    logic              w_slot_end;
    logic              w_frame_wrap;
    logic [3:0]        w_nib;
    logic              w_dp_sel;
    logic              w_zero_run;
    logic [NDIG-1:0]   w_lz_mask;
    logic              w_suppress;
    logic              w_an_on;
    seg_t              w_hex_seg;

    assign w_slot_end   = (r_div_cnt == CW'(DIV - 1));
    assign w_frame_wrap = w_slot_end && (r_dig_idx == DW'(NDIG - 1));
    assign w_an_on      = (int'(r_div_cnt) < (DIV - BLANK));

    // Slot counter and digit index; the digit advances when the slot counter wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_dig_idx <= '0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_dig_idx <= w_frame_wrap ? '0 : r_dig_idx + DW'(1);
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    // Shadow capture and frame-boundary commit; a load on the wrap edge bypasses the shadow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_data   <= '0;
            r_sh_dp     <= '0;
            r_disp_data <= '0;
            r_disp_dp   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (load) begin
                r_sh_data <= value;
                r_sh_dp   <= dp_in;
            end
            if (w_frame_wrap) begin
                if (load) begin
                    r_disp_data <= value;
                    r_disp_dp   <= dp_in;
                end else if (r_pending) begin
                    r_disp_data <= r_sh_data;
                    r_disp_dp   <= r_sh_dp;
                end
                r_pending <= 1'b0;
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Leading-zero mask: digit k is blankable when it and every digit above it are zero
    always_comb begin
        w_lz_mask  = '0;
        w_zero_run = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            w_zero_run   = w_zero_run && (r_disp_data[4*k +: 4] == 4'h0);
            w_lz_mask[k] = w_zero_run;
        end
    end

    // Select the active digit's nibble, decimal point and suppression bit
    always_comb begin
        w_nib      = 4'h0;
        w_dp_sel   = 1'b0;
        w_suppress = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (r_dig_idx == DW'(i)) begin
                w_nib      = r_disp_data[4*i +: 4];
                w_dp_sel   = r_disp_dp[i];
                w_suppress = lz_en && w_lz_mask[i];
            end
        end
    end

    hex u_hex (
        .i_nib (w_nib),
        .o_seg (w_hex_seg)
    );

    // Registered pin drivers, one cycle behind the scan counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_tick <= 1'b0;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_an         <= '1;
        end else begin
            r_frame_tick <= w_frame_wrap;
            r_seg        <= w_suppress ? SEG_BLANK : w_hex_seg;
            r_dp         <= ~w_dp_sel;
            r_an         <= w_an_on ? ~(NDIG'(1) << r_dig_idx) : '1;
        end
    end

    assign pending    = r_pending;
    assign frame_tick = r_frame_tick;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb/tb_hex_scan_ctrl.sv - self-checking bench for hex_scan_ctrl against a frame-level reference model
module tb_hex_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] val = '0;
    logic [3:0]  dpi = '0;
    logic        lz = 1'b0;
    logic        pending, frame_tick, dp;
    logic [6:0]  seg;
    logic [3:0]  an;

    int nchk = 0;
    int nerr = 0;

    // Reference state: cycle count since reset release plus buffer contents
    int          mcyc;
    logic [15:0] m_sh, m_disp;
    logic [3:0]  m_shdp, m_dispdp;
    logic        m_pend;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_dp, e_tick;

    logic [6:0] HEXTAB [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    hex_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ld),
        .value      (val),
        .dp_in      (dpi),
        .lz_en      (lz),
        .pending    (pending),
        .frame_tick (frame_tick),
        .seg        (seg),
        .dp         (dp),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, mcyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        mcyc = 0;
        m_sh = '0; m_disp = '0; m_shdp = '0; m_dispdp = '0; m_pend = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"},   32'(an),         32'hF);
        chk({tag, "_seg"},  32'(seg),        32'h7F);
        chk({tag, "_dp"},   32'(dp),         32'h1);
        chk({tag, "_pend"}, 32'(pending),    32'h0);
        chk({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    // One clock: predict outputs from the pre-edge scan position, update buffers, check at negedge
    task automatic step();
        int c, dig, slot;
        logic [15:0] upper;
        @(posedge clk);
        c     = mcyc;
        slot  = c % DIV;
        dig   = (c / DIV) % NDIG;
        upper = m_disp >> (4 * dig);
        e_seg = (lz && dig != 0 && upper == 16'h0) ? 7'h7F : HEXTAB[upper[3:0]];
        e_an  = (slot < DIV - BLANK) ? ~(4'b0001 << dig) : 4'hF;
        e_dp  = ~m_dispdp[dig];
        e_tick = ((c % FRAME) == FRAME - 1);
        if (e_tick) begin
            if (ld) begin
                m_disp = val; m_dispdp = dpi;
            end else if (m_pend) begin
                m_disp = m_sh; m_dispdp = m_shdp;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        if (ld) begin
            m_sh = val; m_shdp = dpi;
        end
        mcyc++;
        @(negedge clk);
        chk("seg",        32'(seg),        32'(e_seg));
        chk("an",         32'(an),         32'(e_an));
        chk("dp",         32'(dp),         32'(e_dp));
        chk("pending",    32'(pending),    32'(m_pend));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        ld = 1'b1; val = v; dpi = d;
        step();
        ld = 1'b0;
    endtask

    task automatic run_to_wrap_edge();
        for (int i = 0; i < FRAME && (mcyc % FRAME) != FRAME - 1; i++) step();
    endtask

    initial begin
        model_reset();
        // Reset held over several edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;

        // First digit driven on the first edge, idle for three cycles, then load at cycle 3
        run(3);
        pulse_load(16'h1234, 4'h0);
        run(2 * FRAME);

        // Two loads in one frame: the later one wins
        run(3);
        pulse_load(16'hAAAA, 4'h0);
        run(5);
        pulse_load(16'h00F0, 4'h0);
        run(2 * FRAME);

        // Leading-zero suppression with a decimal point on a blanked digit
        lz = 1'b1;
        pulse_load(16'h0040, 4'b0100);
        run(2 * FRAME);
        lz = 1'b0;
        run(FRAME);

        // Load landing exactly on the frame wrap edge
        run_to_wrap_edge();
        pulse_load(16'hBEEF, 4'b1001);
        run(FRAME + 2);

        // Randomised loads, values, decimal points and suppression toggles
        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(0, 9) == 0);
            val = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            dpi = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lz = ~lz;
            step();
        end
        ld = 1'b0;
        lz = 1'b0;

        // Asynchronous half-cycle reset mid-slot with a value pending
        run(3);
        pulse_load(16'h5678, 4'hF);
        run(2);
        chk("pend_before_reset", 32'(pending), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        #1 rst_n = 1'b1;
        model_reset();
        run(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display. It shares one `hex` decoder among all digits by cycling the active anode at a fixed refresh rate. Display data is double-buffered so that a new value is committed only at a frame boundary, which prevents tearing. It sits between the register or status logic that produces hex values and the board's segment/anode pins.

## Interface
- `NDIG`, 4, number of digits; ≥ 2.
- `DIV`, 50000, clock cycles per digit slot; > `BLANK`.
- `BLANK`, 4, cycles at the end of each slot with all anodes off (anti-ghosting); ≥ 0.
- `clk` input 1 — single clock.
- `rst_n` input 1 — asynchronous, active-low reset.
- `load` input 1 — one-cycle strobe; capture `value`/`dp_in`.
- `value` input 4*NDIG — nibble i = digit i (digit 0 = rightmost).
- `dp_in` input NDIG — decimal point per digit, 1 = lit.
- `lz_en` input 1 — leading-zero suppression enable (level, sampled live).
- `pending` output 1 — shadow holds an uncommitted value.
- `frame_tick` output 1 — one-cycle pulse on frame wrap.
- `seg` output 7 — segments a..g, active-low, `hex` encoding.
- `dp` output 1 — decimal point, active-low.
- `an` output NDIG — anode enables, active-low, one-hot or all-high.

## Operation
- Counters:
  - `div_cnt` is `$clog2(DIV)` bits and counts 0..DIV-1, then wraps.
  - On each wrap, `dig_idx` increments, and wraps from NDIG-1 to 0.
- Frame wrap edge: the edge where `dig_idx` goes NDIG-1→0. `frame_tick` is asserted for the cycle after this edge.
- Registers:
  - Shadow register and display register, each holding 4*NDIG data bits plus NDIG dp bits.
- `load`:
  - On `load`, shadow ← `value`/`dp_in` and `pending` ← 1.
  - Repeated loads overwrite the shadow; the last one wins.
- Commit:
  - At the frame wrap edge, if `pending` = 1: display ← shadow, `pending` ← 0.
  - If `load` coincides with the frame wrap edge, display ← `value`/`dp_in` directly and `pending` stays 0.
- Digit selection:
  - Nibble `display[dig_idx]` feeds the `hex` decoder.
  - `an[dig_idx]` = 0 while `div_cnt` < DIV-BLANK; otherwise `an` is all 1.
- Leading-zero suppression (`lz_en` = 1):
  - Digit k is blanked (`seg` = 7'h7F) if nibbles NDIG-1..k are all zero and k ≠ 0.
  - Digit 0 is never suppressed.
  - `dp` is unaffected by suppression.
- Outputs: `seg`, `dp` and `an` are registered, with no combinational path from inputs to pins.

## Timing
- Reset values:
  - `an` = all 1, `seg` = 7'h7F, `dp` = 1.
  - `pending` = 0, `frame_tick` = 0.
  - `div_cnt` = 0, `dig_idx` = 0, shadow = 0, display = 0.
- Output latency: `seg`/`an`/`dp` reflect the (`dig_idx`, `div_cnt`) state of the previous cycle.
- After reset release: digit 0 is first driven (`an[0]` = 0, `seg` = 7'b0000001) on the 1st clock edge.
- Frame period: NDIG*DIV cycles.
- `load`→display worst case: NDIG*DIV cycles.
- Reset mid-scan: all state and outputs return to reset values immediately (asynchronously). A pending shadow value is discarded.
- `lz_en` changes take effect on the next registered output.

## Structure
- Shared package `hex_disp_pkg`:
  - `SEG_BLANK` = 7'h7F.
  - A `seg_t` typedef (logic [6:0]).
  - `DIG_W`/`CNT_W` width helper functions.
- One sub-module instance: `hex` (4-bit → 7-segment decoder), driven by the selected nibble.
- The scan counter, the shadow/commit logic and the suppression mask stay in this module.

## Test plan
Bench parameters: NDIG=4, DIV=8, BLANK=2.
- Reset held, then released with no load:
  - During reset: `an`=4'b1111, `seg`=7'h7F, `dp`=1, `pending`=0.
  - First cycle after release: `an`=4'b1110, `seg`=7'b0000001.
- `load` `value`=16'h1234 at cycle 3:
  - `pending`=1 until the frame wrap edge (cycle 31→32), then 0.
  - In the next frame, digit 0 shows `seg`=7'b1001100 ("4") with `an`=4'b1110, and digit 3 shows 7'b1001111 ("1") with `an`=4'b0111.
  - In slot cycles 6–7, `an`=4'b1111.
- Two loads in one frame (16'hAAAA, then 16'h00F0): only 16'h00F0 is committed. Digit 1 shows 7'b0111000.
- `lz_en`=1 with display 16'h0040:
  - Digits 3 and 2: `seg`=7'h7F.
  - Digit 1: 7'b1001100.
  - Digit 0: 7'b0000001.
  - Same value with `dp_in`=4'b0100: `dp`=0 in the digit 2 slot while its `seg` stays blank.
- `load` exactly on the wrap edge: the new value is visible in the same frame, `pending` stays 0, and `frame_tick` pulses once.
- `rst_n` pulsed low for half a cycle mid-slot with `pending`=1: outputs go to reset values asynchronously, `pending`=0, and after release the display shows 0 on digit 0.
